// File: rtl/lc3_mem_responder_pkg.sv
// Shared definitions for the LC-3 memory responder: MMIO register map,
// access direction encoding and the responder's state encoding.
package lc3_mem_responder_pkg;

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_KBSR,
        SEL_KBDR,
        SEL_DSR,
        SEL_DDR
    } mmio_sel_t;

    // Full 16-bit match: MMIO registers never alias, unlike RAM.
    function automatic mmio_sel_t decode_addr(input logic [15:0] addr);
        case (addr)
            ADDR_KBSR: return SEL_KBSR;
            ADDR_KBDR: return SEL_KBDR;
            ADDR_DSR:  return SEL_DSR;
            ADDR_DDR:  return SEL_DDR;
            default:   return SEL_RAM;
        endcase
    endfunction

endpackage

// File: rtl/lc3_mem_responder_mmio_regs.sv
// Keyboard and display device registers; they are updated on the access
// edge when the responder leaves DONE.
module lc3_mmio_regs
    import lc3_mem_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       done,
    input  logic       rw,
    input  mmio_sel_t  sel,
    input  logic [7:0] wdata,
    input  logic       kb_valid,
    input  logic [7:0] key_char,
    input  logic       disp_ack,
    output logic       kb_ready,
    output logic [7:0] kb_data,
    output logic       ds_ready,
    output logic       disp_valid,
    output logic [7:0] disp_data
);

    logic kbdr_read;
    logic ddr_write;

    assign kbdr_read = done && (rw == RW_READ)  && (sel == SEL_KBDR);
    assign ddr_write = done && (rw == RW_WRITE) && (sel == SEL_DDR);

    // A new keystroke beats a KBDR read-clear; a DDR write beats a display ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_ready   <= 1'b0;
            kb_data    <= 8'h00;
            ds_ready   <= 1'b1;
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
        end else begin
            disp_valid <= ddr_write;
            if (ddr_write) begin
                disp_data <= wdata;
            end
            if (kb_valid) begin
                kb_ready <= 1'b1;
                kb_data  <= key_char;
            end else if (kbdr_read) begin
                kb_ready <= 1'b0;
            end
            if (ddr_write) begin
                ds_ready <= 1'b0;
            end else if (disp_ack) begin
                ds_ready <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 MAR/MDR interface: latches a request,
// waits WAIT_STATES cycles, then completes it and pulses R.
module lc3_mem_responder
    import lc3_mem_responder_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_BITS   = 12
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    output logic [15:0] MEM_OUT,
    output logic        R,
    input  logic        KB_VALID,
    input  logic [7:0]  KB_DATA,
    output logic        DISP_VALID,
    output logic [7:0]  DISP_DATA,
    input  logic        DISP_ACK
);

    localparam int CNT_BITS = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    state_t                state;
    logic [CNT_BITS-1:0]   count;
    logic [15:0]           addr_q;
    logic [15:0]           wdata_q;
    logic                  rw_q;
    mmio_sel_t             sel;
    logic [ADDR_BITS-1:0]  index;
    logic                  done;
    logic [15:0]           rdata;
    logic                  kb_ready;
    logic [7:0]            kb_data;
    logic                  ds_ready;
    logic [15:0]           mem [0:(1<<ADDR_BITS)-1];

    assign sel   = decode_addr(addr_q);
    assign index = addr_q[ADDR_BITS-1:0];
    assign done  = (state == S_DONE);

    always_comb begin
        rdata = mem[index];
        case (sel)
            SEL_KBSR: rdata = {kb_ready, 15'b0};
            SEL_KBDR: rdata = {8'b0, kb_data};
            SEL_DSR:  rdata = {ds_ready, 15'b0};
            SEL_DDR:  rdata = 16'h0000;
            default:  rdata = mem[index];
        endcase
    end

    // The access itself happens on the edge that leaves DONE, so R and
    // MEM_OUT are visible in the following IDLE cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            count   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= RW_READ;
            R       <= 1'b0;
            MEM_OUT <= '0;
        end else begin
            R <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (MIO_EN) begin
                        addr_q  <= MAR;
                        wdata_q <= MDR;
                        rw_q    <= R_W;
                        if (WAIT_STATES > 0) begin
                            state <= S_WAIT;
                            count <= CNT_BITS'(WAIT_STATES - 1);
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    if (count == '0) begin
                        state <= S_DONE;
                    end else begin
                        count <= count - CNT_BITS'(1);
                    end
                end
                S_DONE: begin
                    R     <= 1'b1;
                    state <= S_IDLE;
                    if (rw_q == RW_READ) begin
                        MEM_OUT <= rdata;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (done && (rw_q == RW_WRITE) && (sel == SEL_RAM)) begin
            mem[index] <= wdata_q;
        end
    end

    lc3_mmio_regs u_mmio (
        .clk        (CLK),
        .rst_n      (RST_N),
        .done       (done),
        .rw         (rw_q),
        .sel        (sel),
        .wdata      (wdata_q[7:0]),
        .kb_valid   (KB_VALID),
        .key_char   (KB_DATA),
        .disp_ack   (DISP_ACK),
        .kb_ready   (kb_ready),
        .kb_data    (kb_data),
        .ds_ready   (ds_ready),
        .disp_valid (DISP_VALID),
        .disp_data  (DISP_DATA)
    );

endmodule
